// File: rtl/key_display_ctrl_pkg.sv
// Shared types and constants for the PS/2 key display controller.
// Handshake state encoding, PS/2 prefix bytes, digit slots, BCD helper.
package key_display_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam int DIG_CODE_LO = 0;
    localparam int DIG_CODE_HI = 1;
    localparam int DIG_ASC_LO  = 2;
    localparam int DIG_ASC_HI  = 3;
    localparam int DIG_ONES    = 4;
    localparam int DIG_TENS    = 5;

    // Two-digit BCD increment, 99 rolls over to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd9) r = 8'h00;
            else r = {v[7:4] + 4'd1, 4'h0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/key_display_ctrl_ascii.sv
// Set-2 scan code to lowercase ASCII lookup.
// Letters, digits, space and enter; everything else maps to 0.
module scancode_to_ascii (
    input  logic [7:0] code,
    output logic [7:0] ascii
);

    // Pure ROM: one entry per supported key.
    always_comb begin
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = 8'h61; // a
            8'h32: ascii = 8'h62;
            8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;
            8'h24: ascii = 8'h65;
            8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;
            8'h33: ascii = 8'h68;
            8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;
            8'h42: ascii = 8'h6B;
            8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;
            8'h31: ascii = 8'h6E;
            8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;
            8'h15: ascii = 8'h71;
            8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;
            8'h2C: ascii = 8'h74;
            8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;
            8'h1D: ascii = 8'h77;
            8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;
            8'h1A: ascii = 8'h7A; // z
            8'h45: ascii = 8'h30; // 0
            8'h16: ascii = 8'h31;
            8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;
            8'h25: ascii = 8'h34;
            8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;
            8'h3D: ascii = 8'h37;
            8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39; // 9
            8'h29: ascii = 8'h20; // space
            8'h5A: ascii = 8'h0D; // enter
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/key_display_ctrl.sv
// PS/2 byte consumer: make/break/E0 decode, held key and press count.
// Drives six hex digit nibbles and enables for the 7-segment decoders.
module key_display_ctrl
    import key_display_ctrl_pkg::*;
#(
    parameter int REPEAT_COUNT = 0
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ps2_ready,
    input  logic [7:0]  ps2_data,
    input  logic        ps2_overflow,
    output logic        nextdata_n,
    output logic [23:0] hex_data,
    output logic [5:0]  hex_en,
    output logic        key_down,
    output logic        overflow_led
);

    state_t     state;
    logic [7:0] cur_code;
    logic       cur_ext;
    logic       break_pending;
    logic       ext_pending;
    logic [7:0] count;
    logic [7:0] ascii;
    logic [7:0] ascii_eff;

    scancode_to_ascii u_ascii (
        .code  (cur_code),
        .ascii (ascii)
    );

    // Handshake FSM; a byte is decoded on the edge that leaves IDLE.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state         <= IDLE;
            nextdata_n    <= 1'b1;
            cur_code      <= 8'h00;
            cur_ext       <= 1'b0;
            key_down      <= 1'b0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
            count         <= 8'h00;
            overflow_led  <= 1'b0;
        end else begin
            if (ps2_overflow) overflow_led <= 1'b1;
            unique case (state)
                IDLE: begin
                    nextdata_n <= 1'b1;
                    if (ps2_ready) begin
                        state      <= POP;
                        nextdata_n <= 1'b0;
                        if (ps2_data == PS2_EXT) begin
                            ext_pending <= 1'b1;
                        end else if (ps2_data == PS2_BREAK) begin
                            break_pending <= 1'b1;
                        end else if (!break_pending) begin
                            if (!key_down || ps2_data != cur_code) begin
                                cur_code <= ps2_data;
                                cur_ext  <= ext_pending;
                                key_down <= 1'b1;
                                count    <= bcd_inc(count);
                            end else if (REPEAT_COUNT != 0) begin
                                count <= bcd_inc(count);
                            end
                            ext_pending <= 1'b0;
                        end else begin
                            if (ps2_data == cur_code) key_down <= 1'b0;
                            break_pending <= 1'b0;
                            ext_pending   <= 1'b0;
                        end
                    end
                end
                POP: begin
                    state      <= GAP;
                    nextdata_n <= 1'b1;
                end
                GAP: begin
                    state      <= IDLE;
                    nextdata_n <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    nextdata_n <= 1'b1;
                end
            endcase
        end
    end

    assign ascii_eff = cur_ext ? 8'h00 : ascii;

    // Digit nibbles and enables; blanked digits carry nibble 0.
    always_comb begin
        hex_en   = 6'b000000;
        hex_data = 24'h000000;
        hex_en[DIG_CODE_LO] = key_down;
        hex_en[DIG_CODE_HI] = key_down;
        hex_en[DIG_ASC_LO]  = key_down && (ascii_eff != 8'h00);
        hex_en[DIG_ASC_HI]  = key_down && (ascii_eff != 8'h00);
        hex_en[DIG_ONES]    = 1'b1;
        hex_en[DIG_TENS]    = (count[7:4] != 4'h0);
        if (hex_en[DIG_CODE_LO]) hex_data[3:0]   = cur_code[3:0];
        if (hex_en[DIG_CODE_HI]) hex_data[7:4]   = cur_code[7:4];
        if (hex_en[DIG_ASC_LO])  hex_data[11:8]  = ascii_eff[3:0];
        if (hex_en[DIG_ASC_HI])  hex_data[15:12] = ascii_eff[7:4];
        hex_data[19:16] = count[3:0];
        if (hex_en[DIG_TENS])    hex_data[23:20] = count[7:4];
    end

endmodule

// File: doc/key_display_ctrl.md
Name: key_display_ctrl

Overview:
Consumes the PS/2 keyboard receiver's byte FIFO, decodes make, break and extended (E0) sequences, and tracks the currently held key and a key-press count. Produces six 4-bit nibbles and six enables that drive six hex 7-segment decoder instances directly. Sits between the PS/2 receiver and the seven-segment digit decoders in the character-input display path.

Parameters:
REPEAT_COUNT, 0, 1 = typematic repeats of the held key also increment the press count; 0 = only new presses count.

Ports:
clk  in  1  system clock.
clrn  in  1  reset; synchronous, active-low.
ps2_ready  in  1  receiver FIFO non-empty; ps2_data valid.
ps2_data  in  8  byte at the FIFO head.
ps2_overflow  in  1  receiver FIFO overflow flag.
nextdata_n  out  1  active-low pop strobe to the receiver; one cycle per byte.
hex_data  out  24  six nibbles; [3:0]=digit0 … [23:20]=digit5.
hex_en  out  6  per-digit enable; 0 = digit blank.
key_down  out  1  a key is currently held.
overflow_led  out  1  sticky overflow indicator.

Behaviour:
- All state updates on posedge clk. clrn=0 at an edge: state=IDLE, nextdata_n=1, cur_code=0, cur_ext=0, key_down=0, break_pending=0, ext_pending=0, count=00 (BCD), overflow_led=0. Resulting outputs: hex_en=6'b010000, digit4=0.
- Reset asserted mid-handshake (POP or GAP): nextdata_n is 1 after that edge; the latched byte is discarded.
- FSM:
  - IDLE: if ps2_ready, latch ps2_data and decode it in this cycle. Next state POP.
  - POP: nextdata_n=0 for exactly this cycle. Next state GAP.
  - GAP: nextdata_n=1. Next state IDLE; lets ps2_ready reflect the new FIFO state.
  - At most one byte per 3 cycles. nextdata_n is registered and never low outside POP.
- Decode, applied at latch:
  - 0xE0: ext_pending<=1. Display unchanged.
  - 0xF0: break_pending<=1. Display unchanged.
  - Other byte b with break_pending=0 (make):
    - If key_down=0 or b!=cur_code: cur_code<=b, cur_ext<=ext_pending, key_down<=1, count incremented.
    - Else (typematic repeat): count incremented only if REPEAT_COUNT=1.
    - ext_pending<=0.
  - Other byte b with break_pending=1: if b==cur_code, key_down<=0; otherwise no change. Both pending flags cleared.
- Count: 2-digit BCD; ones 9 wraps to 0 with carry to tens; 99 wraps to 00.
- Outputs are combinational from registered state:
  - digit0/1 = cur_code[3:0]/[7:4]; enabled when key_down.
  - digit2/3 = ascii[3:0]/[7:4], where ascii = scancode_to_ascii(cur_code), forced to 0 when cur_ext=1. Enabled when key_down && ascii!=0.
  - digit4 = count ones; always enabled.
  - digit5 = count tens; enabled when tens!=0 (leading-zero blanking).
  - Disabled digits drive nibble 0.
- overflow_led: set when ps2_overflow=1 at an edge; cleared only by reset.
- A key change while another is held (press B without releasing A) makes B current. A later break of A is ignored; break of B clears key_down.

Decomposition:
- Shared package: state encoding (IDLE/POP/GAP), constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0, digit index constants.
- Sub-module scancode_to_ascii: combinational ROM, set-2 scan code to lowercase ASCII.
  - Covers letters, digits, space (0x29 to 0x20) and enter (0x5A to 0x0D).
  - Unmapped codes return 0.

Test Plan:
- Reset (clrn=0 for 2 cycles) -> hex_en=6'b010000, hex_data=0, nextdata_n=1, key_down=0.
- Feed 1C (make) -> digit1/0=1/C, digit3/2=6/1 (0x61 'a'), count=01, hex_en=6'b011111. Then F0,1C -> hex_en=6'b010000, count stays 01.
- REPEAT_COUNT=0: 1C x5 then F0,1C -> count=01. REPEAT_COUNT=1: same stimulus -> count=05.
- 100 distinct make/break pairs -> count passes 09→10 (digit5 enabled at 10) and ends 99→00 with hex_en[5]=0.
- E0,75 -> scan digits 7/5 shown, hex_en[3:2]=00, count incremented. Also: 1C held, F0,32 -> key_down stays 1, display unchanged.
- Handshake checks:
  - ps2_ready held high -> nextdata_n low exactly 1 cycle per byte, spaced 3 cycles apart.
  - clrn=0 during POP -> nextdata_n=1 after that edge.
  - ps2_overflow pulsed 1 cycle -> overflow_led stays 1 until reset.
